// File: rtl/ir_key_dec.sv
`default_nettype none
// ============================================================================
// Module   : ir_key_dec
// Purpose  : NEC frame/repeat decoder with key-hold tracking and a one-entry
//            valid/ready event buffer. Optional macro: IR_KEY_STRICT_ADDR_EN.
// Revision : 1.0
// ============================================================================
module ir_key_dec #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned RPT_TIMEOUT_US = 120000,
  parameter int unsigned RPT_DELAY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_frame,
  input  logic        i_frame_vld,
  input  logic        i_rpt_vld,
  input  logic        i_key_rdy,
  output logic [7:0]  o_key,
  output logic [15:0] o_addr,
  output logic        o_key_rpt,
  output logic        o_key_vld,
  output logic        o_held,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned c_DIV     = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned c_PRE_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int unsigned c_TO_W    = $clog2(RPT_TIMEOUT_US + 1);
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(c_DIV - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LOAD = c_TO_W'(RPT_TIMEOUT_US);
  localparam logic [c_TO_W-1:0]  c_TO_ONE  = c_TO_W'(1);
  localparam logic [7:0]         c_RPT_DLY = 8'(RPT_DELAY);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_PRE_W-1:0]  r_pre;
  logic [c_TO_W-1:0]   r_to;
  logic [7:0]          r_rpt_cnt;
  logic [7:0]          r_err_cnt;
  logic [7:0]          r_last_key;
  logic [15:0]         r_last_addr;
  logic [7:0]          r_key;
  logic [15:0]         r_addr;
  logic                r_key_rpt;
  logic                r_key_vld;

  logic [7:0]  w_addr, w_addr_inv, w_cmd, w_cmd_inv;
  logic        w_cmd_ok, w_addr_ok, w_frame_ok;
  logic [15:0] w_frame_addr;
  logic        w_tick, w_new_evt, w_rpt_evt, w_load_rpt, w_drain;
  logic [7:0]  w_rpt_next;

  assign w_addr     = i_frame[31:24];
  assign w_addr_inv = i_frame[23:16];
  assign w_cmd      = i_frame[15:8];
  assign w_cmd_inv  = i_frame[7:0];
  assign w_cmd_ok   = (w_cmd == ~w_cmd_inv);
  assign w_addr_ok  = (w_addr == ~w_addr_inv);

`ifdef IR_KEY_STRICT_ADDR_EN
  assign w_frame_ok   = w_cmd_ok && w_addr_ok;
  assign w_frame_addr = {8'h00, w_addr};
`else
  assign w_frame_ok   = w_cmd_ok;
  assign w_frame_addr = w_addr_ok ? {8'h00, w_addr} : {w_addr, w_addr_inv};
`endif

  assign w_tick     = (r_pre == c_PRE_MAX);
  assign w_new_evt  = i_frame_vld && w_frame_ok;
  assign w_rpt_next = (r_rpt_cnt == 8'hFF) ? 8'hFF : r_rpt_cnt + 8'd1;
  // A frame in the same cycle shadows the repeat strobe entirely.
  assign w_rpt_evt  = !i_frame_vld && i_rpt_vld && (r_state == S_HELD) &&
                      (w_rpt_next >= c_RPT_DLY);
  assign w_drain    = r_key_vld && i_key_rdy;
  assign w_load_rpt = w_rpt_evt && (!r_key_vld || i_key_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_to        <= '0;
      r_rpt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_last_key  <= '0;
      r_last_addr <= '0;
      r_key       <= '0;
      r_addr      <= '0;
      r_key_rpt   <= 1'b0;
      r_key_vld   <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + c_PRE_W'(1);

      if (i_frame_vld) begin
        if (w_frame_ok) begin
          r_state     <= S_HELD;
          r_rpt_cnt   <= '0;
          r_to        <= c_TO_LOAD;
          r_last_key  <= w_cmd;
          r_last_addr <= w_frame_addr;
        end else begin
          r_state <= S_IDLE;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
      end else if (r_state == S_HELD) begin
        // Repeat has priority over an expiring timeout.
        if (i_rpt_vld) begin
          r_to      <= c_TO_LOAD;
          r_rpt_cnt <= w_rpt_next;
        end else if (w_tick) begin
          if (r_to <= c_TO_ONE) begin
            r_state <= S_IDLE;
            r_to    <= '0;
          end else begin
            r_to <= r_to - c_TO_ONE;
          end
        end
      end

      // New keypresses may overwrite a stalled buffer; repeats are dropped.
      if (w_new_evt) begin
        r_key     <= w_cmd;
        r_addr    <= w_frame_addr;
        r_key_rpt <= 1'b0;
        r_key_vld <= 1'b1;
      end else if (w_load_rpt) begin
        r_key     <= r_last_key;
        r_addr    <= r_last_addr;
        r_key_rpt <= 1'b1;
        r_key_vld <= 1'b1;
      end else if (w_drain) begin
        r_key_vld <= 1'b0;
      end
    end
  end

  assign o_key     = r_key;
  assign o_addr    = r_addr;
  assign o_key_rpt = r_key_rpt;
  assign o_key_vld = r_key_vld;
  assign o_held    = (r_state == S_HELD);
  assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ir_key_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_key_dec
// Purpose  : Directed self-checking bench for ir_key_dec (1 us tick per cycle).
// Revision : 1.0
// ============================================================================
module tb_ir_key_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_frame = '0;
  logic        i_frame_vld = 1'b0;
  logic        i_rpt_vld = 1'b0;
  logic        i_key_rdy = 1'b1;
  logic [7:0]  o_key;
  logic [15:0] o_addr;
  logic        o_key_rpt;
  logic        o_key_vld;
  logic        o_held;
  logic [7:0]  o_err_cnt;

  int checks = 0;
  int errors = 0;

  ir_key_dec #(
    .CLK_HZ        (1_000_000),
    .RPT_TIMEOUT_US(100),
    .RPT_DELAY     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_frame    (i_frame),
    .i_frame_vld(i_frame_vld),
    .i_rpt_vld  (i_rpt_vld),
    .i_key_rdy  (i_key_rdy),
    .o_key      (o_key),
    .o_addr     (o_addr),
    .o_key_rpt  (o_key_rpt),
    .o_key_vld  (o_key_vld),
    .o_held     (o_held),
    .o_err_cnt  (o_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_frame_vld = 1'b0; i_rpt_vld = 1'b0; i_key_rdy = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f);
    i_frame = f; i_frame_vld = 1'b1;
    step();
    i_frame_vld = 1'b0;
  endtask

  task automatic send_rpt();
    i_rpt_vld = 1'b1;
    step();
    i_rpt_vld = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_key_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", o_key_vld); end
    checks++; if (o_key !== 8'h00) begin errors++; $display("FAIL reset_key: got %h want 00", o_key); end
    checks++; if (o_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", o_addr); end
    checks++; if (o_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", o_held); end
    checks++; if (o_err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err: got %0d want 0", o_err_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(32'h00FF_45BA);
    checks++; if (o_key_vld !== 1'b1) begin errors++; $display("FAIL basic_vld: got %b want 1", o_key_vld); end
    checks++; if (o_key !== 8'h45) begin errors++; $display("FAIL basic_key: got %h want 45", o_key); end
    checks++; if (o_addr !== 16'h0000) begin errors++; $display("FAIL basic_addr: got %h want 0000", o_addr); end
    checks++; if (o_key_rpt !== 1'b0) begin errors++; $display("FAIL basic_rpt: got %b want 0", o_key_rpt); end
    checks++; if (o_held !== 1'b1) begin errors++; $display("FAIL basic_held: got %b want 1", o_held); end
    step();
    checks++; if (o_key_vld !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", o_key_vld); end
  endtask

  task automatic test_ext_addr();
    do_reset();
    send_frame(32'h1234_45BA);
`ifdef IR_KEY_STRICT_ADDR_EN
    checks++; if (o_key_vld !== 1'b0) begin errors++; $display("FAIL ext_vld: got %b want 0", o_key_vld); end
    checks++; if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL ext_err: got %0d want 1", o_err_cnt); end
`else
    checks++; if (o_key_vld !== 1'b1) begin errors++; $display("FAIL ext_vld: got %b want 1", o_key_vld); end
    checks++; if (o_addr !== 16'h1234) begin errors++; $display("FAIL ext_addr: got %h want 1234", o_addr); end
    checks++; if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL ext_err: got %0d want 0", o_err_cnt); end
`endif
  endtask

  task automatic test_bad_frames();
    do_reset();
    send_frame(32'h00FF_45BB);
    checks++; if (o_key_vld !== 1'b0) begin errors++; $display("FAIL bad_vld: got %b want 0", o_key_vld); end
    checks++; if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL bad_err1: got %0d want 1", o_err_cnt); end
    checks++; if (o_held !== 1'b0) begin errors++; $display("FAIL bad_held: got %b want 0", o_held); end
    i_frame_vld = 1'b1;
    for (int i = 0; i < 299; i++) step();
    i_frame_vld = 1'b0;
    checks++; if (o_err_cnt !== 8'd255) begin errors++; $display("FAIL bad_err_sat: got %0d want 255", o_err_cnt); end
    // a bad frame while held drops back to idle
    send_frame(32'h00FF_45BA);
    send_frame(32'h00FF_45BB);
    checks++; if (o_held !== 1'b0) begin errors++; $display("FAIL bad_in_held: got %b want 0", o_held); end
  endtask

  task automatic test_repeat();
    int ev;
    do_reset();
    send_frame(32'h00FF_45BA);
    ev = o_key_vld ? 1 : 0;
    for (int r = 1; r <= 5; r++) begin
      for (int k = 0; k < 49; k++) begin
        step();
        if (o_key_vld) ev++;
      end
      send_rpt();
      if (o_key_vld) ev++;
      checks++; if (o_key_vld !== (r >= 3)) begin errors++; $display("FAIL rpt_vld_%0d: got %b want %b", r, o_key_vld, (r >= 3)); end
      if (r >= 3) begin
        checks++; if (o_key_rpt !== 1'b1 || o_key !== 8'h45) begin errors++; $display("FAIL rpt_evt_%0d: got rpt=%b key=%h want rpt=1 key=45", r, o_key_rpt, o_key); end
      end
    end
    checks++; if (ev !== 4) begin errors++; $display("FAIL rpt_count: got %0d want 4", ev); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_frame(32'h00FF_45BA);
    for (int k = 0; k < 99; k++) step();
    checks++; if (o_held !== 1'b1) begin errors++; $display("FAIL to_held99: got %b want 1", o_held); end
    step();
    checks++; if (o_held !== 1'b0) begin errors++; $display("FAIL to_fall100: got %b want 0", o_held); end
    send_rpt();
    checks++; if (o_key_vld !== 1'b0 || o_held !== 1'b0) begin errors++; $display("FAIL to_rpt_idle: got vld=%b held=%b want 0 0", o_key_vld, o_held); end
    // repeat on the expiry edge keeps the key held
    send_frame(32'h00FF_45BA);
    for (int k = 0; k < 99; k++) step();
    send_rpt();
    checks++; if (o_held !== 1'b1) begin errors++; $display("FAIL to_rpt_expiry: got %b want 1", o_held); end
    for (int k = 0; k < 99; k++) step();
    checks++; if (o_held !== 1'b1) begin errors++; $display("FAIL to_reload99: got %b want 1", o_held); end
    step();
    checks++; if (o_held !== 1'b0) begin errors++; $display("FAIL to_reload100: got %b want 0", o_held); end
  endtask

  task automatic test_backpressure();
    int hs;
    do_reset();
    i_key_rdy = 1'b0;
    send_frame(32'h00FF_45BA);
    send_frame(32'h00FF_16E9);
    send_rpt(); send_rpt(); send_rpt();
    step(); step();
    checks++; if (o_key_vld !== 1'b1 || o_key !== 8'h16 || o_key_rpt !== 1'b0) begin errors++; $display("FAIL bp_hold: got vld=%b key=%h rpt=%b want 1 16 0", o_key_vld, o_key, o_key_rpt); end
    i_key_rdy = 1'b1;
    hs = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_key_vld && i_key_rdy) hs++;
      step();
    end
    checks++; if (hs !== 1) begin errors++; $display("FAIL bp_handshakes: got %0d want 1", hs); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_frame = 32'h00FF_45BA; i_frame_vld = 1'b1;
    step();
    checks++; if (o_key !== 8'h45) begin errors++; $display("FAIL b2b_first: got %h want 45", o_key); end
    i_frame = 32'h00FF_16E9;
    step();
    i_frame_vld = 1'b0;
    checks++; if (o_key_vld !== 1'b1 || o_key !== 8'h16) begin errors++; $display("FAIL b2b_second: got vld=%b key=%h want 1 16", o_key_vld, o_key); end
    step();
    checks++; if (o_key_vld !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", o_key_vld); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(32'h00FF_45BB);
    i_key_rdy = 1'b0;
    send_frame(32'h00FF_45BA);
    rst = 1'b1;
    step();
    checks++; if (o_key_vld !== 1'b0 || o_held !== 1'b0 || o_key !== 8'h00 || o_addr !== 16'h0000 || o_key_rpt !== 1'b0 || o_err_cnt !== 8'h00) begin
      errors++; $display("FAIL reset_mid: got vld=%b held=%b key=%h addr=%h rpt=%b err=%0d want all 0", o_key_vld, o_held, o_key, o_addr, o_key_rpt, o_err_cnt);
    end
    rst = 1'b0; i_key_rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ext_addr();
    test_bad_frames();
    test_repeat();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ir_key_dec.md
Name: ir_key_dec

Overview:
Sits directly downstream of the IR receiver. Consumes 32-bit NEC frames and repeat-code strobes, validates the complement bytes, and tracks key-hold with a repeat timeout. Emits key events through a single-entry valid/ready output buffer to the display or control logic.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; the 1 us tick prescaler divides by CLK_HZ/1_000_000.
RPT_TIMEOUT_US, 120000, key-hold timeout in us after the last frame or repeat code.
RPT_DELAY, 3, repeat-count threshold; auto-repeat events start once the saturating repeat count reaches this value.

Ports:
clk  input  1  system clock.
rst  input  1  reset, synchronous, active-high.
i_frame  input  32  frame, MSB-first as received: [31:24] addr, [23:16] addr_inv, [15:8] cmd, [7:0] cmd_inv.
i_frame_vld  input  1  one-cycle strobe; i_frame is valid this cycle.
i_rpt_vld  input  1  one-cycle strobe; NEC repeat code received.
i_key_rdy  input  1  consumer ready.
o_key  output  8  command byte of the buffered event.
o_addr  output  16  address of the buffered event.
o_key_rpt  output  1  1 = auto-repeat event, 0 = new keypress.
o_key_vld  output  1  buffered event valid.
o_held  output  1  high while in state HELD.
o_err_cnt  output  8  rejected-frame count, saturates at 255.

Behaviour:
- Reset: all outputs 0; state IDLE; prescaler, timeout counter and rpt_cnt all 0.
- Frame check, when i_frame_vld=1:
  - Valid if cmd == ~cmd_inv.
  - o_addr = {8'h00, addr} if addr == ~addr_inv; otherwise extended {addr, addr_inv}.
  - Invalid frame: o_err_cnt+1 (saturating), no event, state -> IDLE.
- States: IDLE, HELD.
  - IDLE + valid frame: emit event (rpt=0); rpt_cnt=0; timeout counter loaded with RPT_TIMEOUT_US; -> HELD.
  - IDLE + i_rpt_vld: ignored.
  - HELD + valid frame: same as from IDLE (new keypress, counters reloaded).
  - HELD + i_rpt_vld: reload timeout; rpt_cnt+1 (saturate at 255); if the new rpt_cnt >= RPT_DELAY, emit event with rpt=1, carrying the last valid key and address.
  - HELD: timeout counter decrements on each 1 us tick; on reaching 0 -> IDLE.
- Simultaneous events:
  - i_frame_vld with i_rpt_vld in the same cycle: frame wins, repeat ignored.
  - Repeat strobe on the same cycle the timeout would expire: repeat wins (reload, stay HELD).
- Output buffer:
  - Emitted event appears on o_key/o_addr/o_key_rpt with o_key_vld=1 the cycle after the strobe (latency 1).
  - Held until the cycle where o_key_vld && i_key_rdy; o_key_vld then clears next cycle unless a new event loads the same cycle.
  - Buffer full and not draining: new-key event overwrites the buffer; repeat event is dropped.
  - Drain and emit in the same cycle: the new event loads and o_key_vld stays 1.
- o_held = (state == HELD), registered.
- Reset asserted mid-HELD or with the buffer full: everything returns to reset values on the next clk edge; any pending event is lost.

Optional Feature:
Macro IR_KEY_STRICT_ADDR_EN.
- Defined: addr == ~addr_inv is also required. A mismatching frame is rejected and counted in o_err_cnt, and o_addr[15:8] is always 0.
- Undefined: extended addressing is accepted as described under Behaviour.

Test Plan:
- Bench uses CLK_HZ=1_000_000 (tick every cycle), RPT_TIMEOUT_US=100, RPT_DELAY=3, i_key_rdy=1 unless stated.
- i_frame=32'h00FF_45BA strobe -> next cycle o_key_vld=1, o_key=8'h45, o_addr=16'h0000, o_key_rpt=0, o_held=1.
- i_frame=32'h1234_45BA -> o_addr=16'h1234. With IR_KEY_STRICT_ADDR_EN defined -> no event, o_err_cnt=1.
- i_frame=32'h00FF_45BB -> no event, o_err_cnt=1, o_held=0. 300 bad frames -> o_err_cnt=255.
- Valid frame, then 5 i_rpt_vld spaced 50 cycles apart -> 4 events total: one with rpt=0, then rpt=1 on the 3rd, 4th and 5th repeat.
- Valid frame with no repeats -> o_held falls 100 ticks later; a later i_rpt_vld produces no event. Repeat strobe on the expiry cycle -> o_held stays 1.
- Backpressure, i_key_rdy=0: frame 0x45, then frame 32'h00FF_16E9, then a repeat -> buffer holds o_key=8'h16, rpt=0; raise i_key_rdy -> exactly one handshake.
- Reset asserted in HELD with o_key_vld=1 -> next cycle all outputs 0.
